hdlc_tx_ctrl: RTL and testbench
===============================

HDLC_TX_CTRL -- requirements
Module: hdlc_tx_ctrl

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning); clock and reset first:
- Clk  in  1  clock.
- Rst  in  1  synchronous, active-high reset.
- Tx_Enable  in  1  frame start strobe.
- Tx_AbortFrame  in  1  abort strobe.
- Tx_DataIn  in  8  show-ahead byte from the Tx buffer; valid whenever Tx_Empty=0.
- Tx_Empty  in  1  Tx buffer empty.
- Tx_RdBuff  out  1  one-cycle buffer pop.
- Tx  out  1  serial line, registered.
- Tx_ValidFrame  out  1  frame in progress.
- Tx_Done  out  1  one-cycle pulse at frame completion.
- Tx_AbortedTrans  out  1  one-cycle pulse at abort completion.
- Tx_Overflow  out  1  one-cycle pulse when the frame-length limit is hit.
REQ-002 SHALL emit one line bit per Clk, bytes LSB first.

Function
REQ-003 SHALL implement the states IDLE, START_FLAG, DATA, END_FLAG and ABORT.
REQ-004 IDLE: Tx=1. Tx_Enable=1 moves to START_FLAG; the first flag bit appears on Tx the next cycle.
REQ-005 START_FLAG and END_FLAG SHALL each output 0,1,1,1,1,1,1,0 (0x7E) over 8 cycles, with no zero insertion.
REQ-006 On the last START_FLAG bit, SHALL do one of the following:
- Tx_Empty=0: latch Tx_DataIn, pulse Tx_RdBuff in that cycle, go to DATA.
- Tx_Empty=1: go to END_FLAG (empty frame).
REQ-007 DATA zero insertion: after five consecutive 1s on Tx, SHALL output one 0 without advancing the bit index. The ones counter clears on any 0 and at each flag.
REQ-008 DATA byte boundary: after bit 7 is output and any pending stuff 0 is sent, SHALL do one of the following:
- Tx_Empty=0: load the next byte and pulse Tx_RdBuff.
- Tx_Empty=1: go to END_FLAG.
REQ-009 After the last END_FLAG bit, SHALL pulse Tx_Done for one cycle and return to IDLE (Tx=1).
REQ-010 Tx_AbortFrame=1 in START_FLAG, DATA or END_FLAG SHALL enter ABORT on the next cycle.
REQ-011 ABORT SHALL output 0 then seven 1s, pulse Tx_AbortedTrans on the cycle after the last 1, then go to IDLE. It SHALL issue no further Tx_RdBuff.
REQ-012 Tx_AbortFrame in IDLE or ABORT SHALL be ignored. Tx_Enable outside IDLE SHALL be ignored. Both asserted together in IDLE: Tx_Enable wins.
REQ-013 Tx_ValidFrame SHALL be 1 exactly in START_FLAG, DATA and END_FLAG. It SHALL be 0 in IDLE and ABORT.
REQ-014 Tx_RdBuff SHALL never assert while Tx_Empty=1, and SHALL assert at most once per byte.

Reset
REQ-015 While Rst=1 at a Clk edge, the block SHALL set all of the following, including mid-frame:
- state=IDLE
- Tx=1
- Tx_ValidFrame=0
- Tx_RdBuff=0
- Tx_Done=0
- Tx_AbortedTrans=0
- Tx_Overflow=0
- ones counter, bit index and byte counter = 0
REQ-016 Reset SHALL NOT produce a Tx_Done or Tx_AbortedTrans pulse.

Configuration
REQ-017 Macro HDLC_TX_MAXLEN_EN defined: an 8-bit byte counter SHALL count bytes loaded per frame. At a byte boundary with count=126 and Tx_Empty=0, the block SHALL pulse Tx_Overflow, enter ABORT, and not pop the buffer.
REQ-018 Macro HDLC_TX_MAXLEN_EN undefined: frames SHALL be unlimited, no byte counter SHALL exist, and Tx_Overflow SHALL be tied 0.

Verification
REQ-019 Empty frame: Tx_Empty=1, Tx_Enable pulse → Tx=0111111001111110, Tx_RdBuff never asserts, Tx_Done pulses once, Tx_ValidFrame high for 16 cycles.
REQ-020 Byte 0xA5 → Tx=01111110 10100101 01111110 (LSB first), one Tx_RdBuff, no stuffed bits.
REQ-021 Byte 0xFF → data bits 11111 0 111, then end flag (9 data cycles). Byte 0x1F → 11111 0 000.
REQ-022 Abort at the 3rd data bit of 0x00 → next cycle Tx=0 then 1111111; Tx_AbortedTrans pulse; Tx_ValidFrame falls on ABORT entry.
REQ-023 Rst=1 mid-DATA → next cycle Tx=1 and Tx_ValidFrame=0, no pulses. A subsequent Tx_Enable starts a clean frame.
REQ-024 HDLC_TX_MAXLEN_EN defined, buffer holding 130 bytes → exactly 126 Tx_RdBuff, Tx_Overflow pulse, abort pattern, no Tx_Done.

Source files
------------

// File: rtl/hdlc_tx_ctrl.sv
// hdlc_tx_ctrl: HDLC transmit framer. Wraps bytes from a show-ahead Tx buffer
// in 0x7E flags, sends them LSB first with zero insertion, and supports abort.
// Optional build macro HDLC_TX_MAXLEN_EN: limits a frame to 126 payload bytes;
// a 127th byte raises Tx_Overflow and aborts the frame instead.
module hdlc_tx_ctrl (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_DataIn,
    input  logic       Tx_Empty,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Overflow
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned ONES_W = 3;

    localparam logic [BYTE_W-1:0] FLAG_BYTE = BYTE_W'(8'h7E);
    localparam logic [ONES_W-1:0] STUFF_RUN = ONES_W'(5);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(7);

`ifdef HDLC_TX_MAXLEN_EN
    localparam int unsigned       CNT_W     = 8;
    localparam logic [CNT_W-1:0]  MAX_BYTES = CNT_W'(126);
`endif

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_FLAG = 3'd1,
        DATA       = 3'd2,
        END_FLAG   = 3'd3,
        ABORT      = 3'd4
    } state_t;

    state_t            state;
    logic [BYTE_W-1:0] data_q;    // byte currently being serialised
    logic [IDX_W-1:0]  bit_idx;   // index of the bit currently on Tx
    logic [ONES_W-1:0] ones_cnt;  // consecutive data ones currently on the line

`ifdef HDLC_TX_MAXLEN_EN
    logic [CNT_W-1:0]  byte_cnt;  // bytes loaded in the current frame
`endif

    logic [IDX_W-1:0]  next_idx;
    logic              in_frame;
    logic              abort_req;
    logic              last_bit;
    logic              data_next_bit;
    logic [ONES_W-1:0] data_next_ones;
    logic [ONES_W-1:0] load_ones;

    // Next-bit helpers shared by the sequencer
    always_comb begin
        next_idx       = bit_idx + IDX_W'(1);
        in_frame       = (state == START_FLAG) || (state == DATA) || (state == END_FLAG);
        abort_req      = Tx_AbortFrame && in_frame;
        last_bit       = (bit_idx == LAST_IDX);
        data_next_bit  = data_q[next_idx];
        data_next_ones = data_next_bit ? (ones_cnt + ONES_W'(1)) : '0;
        load_ones      = Tx_DataIn[0] ? (ones_cnt + ONES_W'(1)) : '0;
    end

    // Framing state machine; every output is registered here
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= IDLE;
            Tx              <= 1'b1;
            Tx_ValidFrame   <= 1'b0;
            Tx_RdBuff       <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            data_q          <= '0;
            bit_idx         <= '0;
            ones_cnt        <= '0;
`ifdef HDLC_TX_MAXLEN_EN
            byte_cnt        <= '0;
            Tx_Overflow     <= 1'b0;
`endif
        end else begin
            Tx_RdBuff       <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
`ifdef HDLC_TX_MAXLEN_EN
            Tx_Overflow     <= 1'b0;
`endif
            if (abort_req) begin
                // Abort wins over any in-frame action, including a pending pop
                state         <= ABORT;
                Tx            <= 1'b0;
                Tx_ValidFrame <= 1'b0;
                bit_idx       <= '0;
                ones_cnt      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        Tx       <= 1'b1;
                        bit_idx  <= '0;
                        ones_cnt <= '0;
                        if (Tx_Enable) begin
                            state         <= START_FLAG;
                            Tx            <= FLAG_BYTE[0];
                            Tx_ValidFrame <= 1'b1;
`ifdef HDLC_TX_MAXLEN_EN
                            byte_cnt      <= '0;
`endif
                        end
                    end

                    START_FLAG: begin
                        if (!last_bit) begin
                            bit_idx <= next_idx;
                            Tx      <= FLAG_BYTE[next_idx];
                        end else if (Tx_Empty) begin
                            // Nothing queued: close with an empty frame
                            state    <= END_FLAG;
                            Tx       <= FLAG_BYTE[0];
                            bit_idx  <= '0;
                            ones_cnt <= '0;
                        end else begin
                            state     <= DATA;
                            data_q    <= Tx_DataIn;
                            Tx        <= Tx_DataIn[0];
                            bit_idx   <= '0;
                            ones_cnt  <= load_ones;
                            Tx_RdBuff <= 1'b1;
`ifdef HDLC_TX_MAXLEN_EN
                            byte_cnt  <= byte_cnt + CNT_W'(1);
`endif
                        end
                    end

                    DATA: begin
                        if (ones_cnt == STUFF_RUN) begin
                            // Stuffed zero; bit index holds so the boundary check follows it
                            Tx       <= 1'b0;
                            ones_cnt <= '0;
                        end else if (!last_bit) begin
                            bit_idx  <= next_idx;
                            Tx       <= data_next_bit;
                            ones_cnt <= data_next_ones;
                        end else if (Tx_Empty) begin
                            state    <= END_FLAG;
                            Tx       <= FLAG_BYTE[0];
                            bit_idx  <= '0;
                            ones_cnt <= '0;
`ifdef HDLC_TX_MAXLEN_EN
                        end else if (byte_cnt == MAX_BYTES) begin
                            // Frame too long: abort without popping the waiting byte
                            state         <= ABORT;
                            Tx            <= 1'b0;
                            Tx_ValidFrame <= 1'b0;
                            Tx_Overflow   <= 1'b1;
                            bit_idx       <= '0;
                            ones_cnt      <= '0;
`endif
                        end else begin
                            // Ones run carries across the byte boundary
                            data_q    <= Tx_DataIn;
                            Tx        <= Tx_DataIn[0];
                            bit_idx   <= '0;
                            ones_cnt  <= load_ones;
                            Tx_RdBuff <= 1'b1;
`ifdef HDLC_TX_MAXLEN_EN
                            byte_cnt  <= byte_cnt + CNT_W'(1);
`endif
                        end
                    end

                    END_FLAG: begin
                        if (!last_bit) begin
                            bit_idx <= next_idx;
                            Tx      <= FLAG_BYTE[next_idx];
                        end else begin
                            state         <= IDLE;
                            Tx            <= 1'b1;
                            Tx_ValidFrame <= 1'b0;
                            Tx_Done       <= 1'b1;
                            bit_idx       <= '0;
                        end
                    end

                    ABORT: begin
                        // 0 already sent on entry, then seven 1s
                        if (!last_bit) begin
                            bit_idx <= next_idx;
                            Tx      <= 1'b1;
                        end else begin
                            state           <= IDLE;
                            Tx              <= 1'b1;
                            Tx_AbortedTrans <= 1'b1;
                            bit_idx         <= '0;
                        end
                    end

                    default: begin
                        state         <= IDLE;
                        Tx            <= 1'b1;
                        Tx_ValidFrame <= 1'b0;
                        bit_idx       <= '0;
                        ones_cnt      <= '0;
                    end
                endcase
            end
        end
    end

`ifndef HDLC_TX_MAXLEN_EN
    // Unlimited frames: no length limit to report
    assign Tx_Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_tx_ctrl.sv
// tb_hdlc_tx_ctrl: directed frame vectors with hand-computed line patterns,
// plus reset, idle-abort and long-frame sequences.
module tb_hdlc_tx_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Tx_Enable = 1'b0;
    logic       Tx_AbortFrame = 1'b0;
    logic [7:0] Tx_DataIn = 8'h00;
    logic       Tx_Empty = 1'b1;
    logic       Tx_RdBuff;
    logic       Tx;
    logic       Tx_ValidFrame;
    logic       Tx_Done;
    logic       Tx_AbortedTrans;
    logic       Tx_Overflow;

    int n_pass  = 0;
    int n_total = 0;

    hdlc_tx_ctrl dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Tx_Enable       (Tx_Enable),
        .Tx_AbortFrame   (Tx_AbortFrame),
        .Tx_DataIn       (Tx_DataIn),
        .Tx_Empty        (Tx_Empty),
        .Tx_RdBuff       (Tx_RdBuff),
        .Tx              (Tx),
        .Tx_ValidFrame   (Tx_ValidFrame),
        .Tx_Done         (Tx_Done),
        .Tx_AbortedTrans (Tx_AbortedTrans),
        .Tx_Overflow     (Tx_Overflow)
    );

    always #5 Clk = ~Clk;

    // One frame scenario: buffer contents, strobes, and the expected line
    // pattern written in transmit order (first bit leftmost, exp_len bits).
    typedef struct {
        int          nbytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          abort_at;
        int          reen_at;
        bit          abt_en;
        logic [63:0] exp_bits;
        int          exp_len;
        int          exp_rd;
        int          exp_done;
        int          exp_abt;
        int          exp_valid;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                                input int abort_at, input int reen_at, input bit abt_en,
                                input logic [63:0] bits, input int len, input int rd,
                                input int done, input int abt, input int valid);
        vec_t v;
        v.nbytes = nb;     v.b0 = b0;           v.b1 = b1;
        v.abort_at = abort_at; v.reen_at = reen_at; v.abt_en = abt_en;
        v.exp_bits = bits; v.exp_len = len;     v.exp_rd = rd;
        v.exp_done = done; v.exp_abt = abt;     v.exp_valid = valid;
        return v;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic check_bits(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b required %b", name, act, exp);
    endtask

    // Drive one frame with a show-ahead buffer model; pops land at the edge
    // closing a cycle in which Tx_RdBuff was high.
    task automatic run_vec(input vec_t v, input int id);
        logic [7:0]  q[$];
        logic [63:0] got = '0;
        logic        pop_pend = 1'b0;
        int rd_cnt = 0, rd_empty = 0, done_cnt = 0, abt_cnt = 0, ovf_cnt = 0;
        int done_at = -1, abt_at = -1, valid_cnt = 0, valid_late = 0, idle_tx = 0;
        int win = v.exp_len + 4;
        for (int i = 0; i < v.nbytes; i++) q.push_back(i == 0 ? v.b0 : v.b1);
        Tx_Empty      = (q.size() == 0);
        Tx_DataIn     = (q.size() != 0) ? q[0] : 8'h00;
        Tx_Enable     = 1'b1;
        Tx_AbortFrame = v.abt_en;
        for (int c = 0; c < win; c++) begin
            @(posedge Clk); #1;
            if (pop_pend && q.size() != 0) void'(q.pop_front());
            pop_pend = Tx_RdBuff;
            if (Tx_RdBuff) begin
                rd_cnt++;
                if (q.size() == 0) rd_empty++;
            end
            if (c < v.exp_len) got[v.exp_len-1-c] = Tx;
            if (c == v.exp_len) idle_tx = int'(Tx);
            if (Tx_Done) begin done_cnt++; if (done_at < 0) done_at = c; end
            if (Tx_AbortedTrans) begin abt_cnt++; if (abt_at < 0) abt_at = c; end
            if (Tx_Overflow) ovf_cnt++;
            if (Tx_ValidFrame) begin valid_cnt++; if (c >= v.exp_valid) valid_late++; end
            Tx_Enable     = (c == v.reen_at);
            Tx_AbortFrame = (c == v.abort_at);
            Tx_Empty      = (q.size() == 0);
            Tx_DataIn     = (q.size() != 0) ? q[0] : 8'h00;
        end
        Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0; Tx_Empty = 1'b1; Tx_DataIn = 8'h00;
        check_bits($sformatf("v%0d tx_bits", id), got, v.exp_bits);
        check_int($sformatf("v%0d tx_idle_after", id), idle_tx, 1);
        check_int($sformatf("v%0d rdbuff_count", id), rd_cnt, v.exp_rd);
        check_int($sformatf("v%0d rdbuff_when_empty", id), rd_empty, 0);
        check_int($sformatf("v%0d done_count", id), done_cnt, v.exp_done);
        check_int($sformatf("v%0d done_cycle", id), done_at, v.exp_done != 0 ? v.exp_len : -1);
        check_int($sformatf("v%0d aborted_count", id), abt_cnt, v.exp_abt);
        check_int($sformatf("v%0d aborted_cycle", id), abt_at, v.exp_abt != 0 ? v.exp_len : -1);
        check_int($sformatf("v%0d valid_cycles", id), valid_cnt, v.exp_valid);
        check_int($sformatf("v%0d valid_late", id), valid_late, 0);
        check_int($sformatf("v%0d overflow_count", id), ovf_cnt, 0);
    endtask

    // 130 zero bytes queued; bounded run until the frame ends either way
    task automatic run_long();
        logic [7:0] q[$];
        logic pop_pend = 1'b0;
        int rd_cnt = 0, rd_empty = 0, done_cnt = 0, abt_cnt = 0, ovf_cnt = 0, ended = 0;
        for (int i = 0; i < 130; i++) q.push_back(8'h00);
        Tx_Empty = 1'b0; Tx_DataIn = 8'h00; Tx_Enable = 1'b1;
        for (int c = 0; c < 3000 && ended < 3; c++) begin
            @(posedge Clk); #1;
            Tx_Enable = 1'b0;
            if (pop_pend && q.size() != 0) void'(q.pop_front());
            pop_pend = Tx_RdBuff;
            if (Tx_RdBuff) begin
                rd_cnt++;
                if (q.size() == 0) rd_empty++;
            end
            if (Tx_Done) done_cnt++;
            if (Tx_AbortedTrans) abt_cnt++;
            if (Tx_Overflow) ovf_cnt++;
            if (ended > 0 || Tx_Done || Tx_AbortedTrans) ended++;
            Tx_Empty  = (q.size() == 0);
            Tx_DataIn = (q.size() != 0) ? q[0] : 8'h00;
        end
        Tx_Empty = 1'b1;
        check_int("long frame_ended", int'(ended > 0), 1);
        check_int("long rdbuff_when_empty", rd_empty, 0);
`ifdef HDLC_TX_MAXLEN_EN
        check_int("long rdbuff_count", rd_cnt, 126);
        check_int("long overflow_count", ovf_cnt, 1);
        check_int("long done_count", done_cnt, 0);
        check_int("long aborted_count", abt_cnt, 1);
`else
        check_int("long rdbuff_count", rd_cnt, 130);
        check_int("long overflow_count", ovf_cnt, 0);
        check_int("long done_count", done_cnt, 1);
        check_int("long aborted_count", abt_cnt, 0);
`endif
    endtask

    initial begin
        int pulses;
        int tx_low;

        //           nb  b0     b1     abort reen abt_en bits                                                   len rd dn ab valid
        vecs[0]  = mk(0, 8'h00, 8'h00, -1,  -1,  1'b0, 64'b01111110_01111110,                                  16, 0, 1, 0, 16);
        vecs[1]  = mk(0, 8'h00, 8'h00, -1,  -1,  1'b1, 64'b01111110_01111110,                                  16, 0, 1, 0, 16);
        vecs[2]  = mk(1, 8'hA5, 8'h00, -1,  12,  1'b0, 64'b01111110_10100101_01111110,                         24, 1, 1, 0, 24);
        vecs[3]  = mk(1, 8'hFF, 8'h00, -1,  -1,  1'b0, 64'b01111110_111110111_01111110,                        25, 1, 1, 0, 25);
        vecs[4]  = mk(1, 8'h1F, 8'h00, -1,  -1,  1'b0, 64'b01111110_111110000_01111110,                        25, 1, 1, 0, 25);
        vecs[5]  = mk(1, 8'hF8, 8'h00, -1,  -1,  1'b0, 64'b01111110_000111110_01111110,                        25, 1, 1, 0, 25);
        vecs[6]  = mk(1, 8'h3E, 8'h00, -1,  -1,  1'b0, 64'b01111110_011111000_01111110,                        25, 1, 1, 0, 25);
        vecs[7]  = mk(2, 8'hFF, 8'hFF, -1,  -1,  1'b0, 64'b01111110_111110111_1101111101_01111110,             35, 2, 1, 0, 35);
        vecs[8]  = mk(1, 8'hA5, 8'h00,  3,  -1,  1'b0, 64'b0111_01111111,                                      12, 0, 0, 1, 4);
        vecs[9]  = mk(1, 8'h00, 8'h00, 10,  -1,  1'b0, 64'b01111110_000_01111111,                              19, 1, 0, 1, 11);
        vecs[10] = mk(1, 8'hA5, 8'h00, 20,  -1,  1'b0, 64'b01111110_10100101_01111_01111111,                   29, 1, 0, 1, 21);

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check_int("reset tx", int'(Tx), 1);
        check_int("reset valid", int'(Tx_ValidFrame), 0);
        check_int("reset rdbuff", int'(Tx_RdBuff), 0);
        check_int("reset done", int'(Tx_Done), 0);
        check_int("reset aborted", int'(Tx_AbortedTrans), 0);
        check_int("reset overflow", int'(Tx_Overflow), 0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Abort strobe in IDLE is ignored
        pulses = 0; tx_low = 0;
        Tx_AbortFrame = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clk); #1;
            if (c == 1) Tx_AbortFrame = 1'b0;
            if (Tx_AbortedTrans || Tx_ValidFrame || Tx_Done) pulses++;
            if (!Tx) tx_low++;
        end
        check_int("idle_abort activity", pulses, 0);
        check_int("idle_abort tx_low", tx_low, 0);

        // Reset in the middle of DATA
        Tx_DataIn = 8'h00; Tx_Empty = 1'b0; Tx_Enable = 1'b1;
        @(posedge Clk); #1;
        Tx_Enable = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        check_int("midreset precondition valid", int'(Tx_ValidFrame), 1);
        Rst = 1'b1;
        @(posedge Clk); #1;
        check_int("midreset tx", int'(Tx), 1);
        check_int("midreset valid", int'(Tx_ValidFrame), 0);
        check_int("midreset rdbuff", int'(Tx_RdBuff), 0);
        check_int("midreset done", int'(Tx_Done), 0);
        check_int("midreset aborted", int'(Tx_AbortedTrans), 0);
        Rst = 1'b0; Tx_Empty = 1'b1;
        pulses = 0; tx_low = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge Clk); #1;
            if (Tx_Done || Tx_AbortedTrans || Tx_RdBuff || Tx_ValidFrame) pulses++;
            if (!Tx) tx_low++;
        end
        check_int("midreset after pulses", pulses, 0);
        check_int("midreset after tx_low", tx_low, 0);
        run_vec(vecs[2], 20);

        run_long();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
